// File: rtl/hdmi_pkg.sv
// Shared constants, control-period codes and FSM state type for the HDMI
// period scheduler and its timing counter.
package hdmi_pkg;

  localparam int unsigned CntW        = 12;
  localparam int unsigned PreambleLen = 8;
  localparam int unsigned GuardLen    = 2;

  // Video guard-band symbols substituted downstream while guard is high.
  localparam logic [9:0] GuardCodeCh0 = 10'b1011001100;
  localparam logic [9:0] GuardCodeCh1 = 10'b0100110011;
  localparam logic [9:0] GuardCodeCh2 = 10'b1011001100;

  // Video preamble: CTL0=1, CTL1=0, CTL2=0, CTL3=0.
  localparam logic [1:0] PreambleCh1 = 2'b01;
  localparam logic [1:0] PreambleCh2 = 2'b00;

  typedef enum logic [2:0] {
    StIdle,
    StCtrl,
    StPreamble,
    StGuard,
    StVideo
  } period_state_e;

endpackage

// File: rtl/hdmi_period_scheduler_if.sv
// Run enable plus the per-pixel period/control outputs of the scheduler.
interface hdmi_period_scheduler_if;

  logic                      en;
  logic                      de;
  logic [1:0]                ch0_c;
  logic [1:0]                ch1_c;
  logic [1:0]                ch2_c;
  logic                      guard;
  logic                      pix_req;
  logic [hdmi_pkg::CntW-1:0] pix_x;
  logic [hdmi_pkg::CntW-1:0] pix_y;
  logic                      frame_start;

  modport master (
    input  en,
    output de, ch0_c, ch1_c, ch2_c, guard, pix_req, pix_x, pix_y, frame_start
  );

  modport slave (
    output en,
    input  de, ch0_c, ch1_c, ch2_c, guard, pix_req, pix_x, pix_y, frame_start
  );

endinterface

// File: rtl/video_timing_counter.sv
// Raster position counters with sync decode; exposes the next-cycle position so
// the owner can register outputs aligned to the counter.
module video_timing_counter
  import hdmi_pkg::*;
#(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            advance,
  output logic [CntW-1:0] h_nxt,
  output logic [CntW-1:0] v_nxt,
  output logic            hs_nxt,
  output logic            vs_nxt
);

  localparam logic [CntW-1:0] HLast      = CntW'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [CntW-1:0] HSyncStart = CntW'(H_ACTIVE + H_FP);
  localparam logic [CntW-1:0] HSyncEnd   = CntW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CntW-1:0] VLast      = CntW'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
  localparam logic [CntW-1:0] VSyncStart = CntW'(V_ACTIVE + V_FP);
  localparam logic [CntW-1:0] VSyncEnd   = CntW'(V_ACTIVE + V_FP + V_SYNC);
  // Idle home position: first blank line, so line 0 gets a full lead-in.
  localparam logic [CntW-1:0] VHome      = CntW'(V_ACTIVE);

  logic [CntW-1:0] h_q, h_d;
  logic [CntW-1:0] v_q, v_d;

  always_comb begin
    h_d = h_q;
    v_d = v_q;
    if (!advance) begin
      h_d = '0;
      v_d = VHome;
    end else if (h_q == HLast) begin
      h_d = '0;
      v_d = (v_q == VLast) ? '0 : v_q + 1'b1;
    end else begin
      h_d = h_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      h_q <= '0;
      v_q <= VHome;
    end else begin
      h_q <= h_d;
      v_q <= v_d;
    end
  end

  assign h_nxt  = h_d;
  assign v_nxt  = v_d;
  assign hs_nxt = (h_d >= HSyncStart) && (h_d < HSyncEnd);
  assign vs_nxt = (v_d >= VSyncStart) && (v_d < VSyncEnd);

endmodule

// File: rtl/hdmi_period_scheduler.sv
// Video timing generator and TMDS period sequencer (control, preamble, guard
// band, video) with a one-cycle-early pixel request.
module hdmi_period_scheduler
  import hdmi_pkg::*;
#(
  parameter int unsigned H_ACTIVE  = 640,
  parameter int unsigned H_FP      = 16,
  parameter int unsigned H_SYNC    = 96,
  parameter int unsigned H_BP      = 48,
  parameter int unsigned V_ACTIVE  = 480,
  parameter int unsigned V_FP      = 10,
  parameter int unsigned V_SYNC    = 2,
  parameter int unsigned V_BP      = 33,
  parameter bit          HSYNC_POL = 1'b0,
  parameter bit          VSYNC_POL = 1'b0,
  parameter bit          HDMI_MODE = 1'b1
) (
  input logic                     clk,
  input logic                     resetn,
  hdmi_period_scheduler_if.master bus
);

  localparam int unsigned     HTotal     = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam logic [CntW-1:0] HLast      = CntW'(HTotal - 1);
  localparam logic [CntW-1:0] HActive    = CntW'(H_ACTIVE);
  localparam logic [CntW-1:0] PreStart   = CntW'(HTotal - PreambleLen - GuardLen);
  localparam logic [CntW-1:0] GuardStart = CntW'(HTotal - GuardLen);
  localparam logic [CntW-1:0] VLast      = CntW'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
  localparam logic [CntW-1:0] VActive    = CntW'(V_ACTIVE);
  localparam logic [CntW-1:0] VActiveM1  = CntW'(V_ACTIVE - 1);
  localparam logic [1:0]      SyncIdle   = {~VSYNC_POL, ~HSYNC_POL};

  if (HDMI_MODE && (H_BP < PreambleLen + GuardLen)) begin : g_bp_check
    $error("H_BP too short to hold preamble and guard band in HDMI mode");
  end

  period_state_e   state_q, state_d;
  logic [CntW-1:0] h_nxt, v_nxt;
  logic            hs_nxt, vs_nxt;
  logic            advance;
  logic            line_on, next_line_on;

  assign advance = bus.en && (state_q != StIdle);

  video_timing_counter #(
    .H_ACTIVE (H_ACTIVE),
    .H_FP     (H_FP),
    .H_SYNC   (H_SYNC),
    .H_BP     (H_BP),
    .V_ACTIVE (V_ACTIVE),
    .V_FP     (V_FP),
    .V_SYNC   (V_SYNC),
    .V_BP     (V_BP)
  ) u_counter (
    .clk     (clk),
    .resetn  (resetn),
    .advance (advance),
    .h_nxt   (h_nxt),
    .v_nxt   (v_nxt),
    .hs_nxt  (hs_nxt),
    .vs_nxt  (vs_nxt)
  );

  assign line_on      = v_nxt < VActive;
  assign next_line_on = (v_nxt == VLast) || (v_nxt < VActiveM1);

  // State transitions are decided on the position the counter moves to.
  always_comb begin
    state_d = state_q;
    if (!bus.en) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle: state_d = StCtrl;
        StCtrl: begin
          if (HDMI_MODE && (h_nxt == PreStart) && next_line_on) begin
            state_d = StPreamble;
          end else if (!HDMI_MODE && (h_nxt == '0) && line_on) begin
            state_d = StVideo;
          end
        end
        StPreamble: if (h_nxt == GuardStart) state_d = StGuard;
        StGuard:    if (h_nxt == '0)         state_d = StVideo;
        StVideo:    if (h_nxt == HActive)    state_d = StCtrl;
        default:    state_d = StIdle;
      endcase
    end
  end

  logic            de_d, guard_d, req_d, fs_d, wrap;
  logic [1:0]      ch0_d, ch1_d, ch2_d;
  logic [CntW-1:0] x_ahead, y_ahead, x_d, y_d;

  // Pixel request looks one position past the one the outputs move to.
  always_comb begin
    wrap    = h_nxt == HLast;
    x_ahead = wrap ? '0 : h_nxt + 1'b1;
    y_ahead = v_nxt;
    if (wrap) y_ahead = (v_nxt == VLast) ? '0 : v_nxt + 1'b1;

    de_d    = state_d == StVideo;
    guard_d = state_d == StGuard;
    ch1_d   = (state_d == StPreamble) ? PreambleCh1 : 2'b00;
    ch2_d   = (state_d == StPreamble) ? PreambleCh2 : 2'b00;
    ch0_d   = SyncIdle;
    if (state_d != StIdle) begin
      ch0_d = {vs_nxt ? VSYNC_POL : ~VSYNC_POL, hs_nxt ? HSYNC_POL : ~HSYNC_POL};
    end

    req_d = (state_d != StIdle) && (y_ahead < VActive) && (x_ahead < HActive);
    x_d   = req_d ? x_ahead : '0;
    y_d   = req_d ? y_ahead : '0;
    fs_d  = req_d && (x_ahead == '0) && (y_ahead == '0);
  end

  logic            de_q, guard_q, req_q, fs_q;
  logic [1:0]      ch0_q, ch1_q, ch2_q;
  logic [CntW-1:0] x_q, y_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= StIdle;
      de_q    <= 1'b0;
      guard_q <= 1'b0;
      ch0_q   <= SyncIdle;
      ch1_q   <= 2'b00;
      ch2_q   <= 2'b00;
      req_q   <= 1'b0;
      x_q     <= '0;
      y_q     <= '0;
      fs_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      de_q    <= de_d;
      guard_q <= guard_d;
      ch0_q   <= ch0_d;
      ch1_q   <= ch1_d;
      ch2_q   <= ch2_d;
      req_q   <= req_d;
      x_q     <= x_d;
      y_q     <= y_d;
      fs_q    <= fs_d;
    end
  end

  assign bus.de          = de_q;
  assign bus.guard       = guard_q;
  assign bus.ch0_c       = ch0_q;
  assign bus.ch1_c       = ch1_q;
  assign bus.ch2_c       = ch2_q;
  assign bus.pix_req     = req_q;
  assign bus.pix_x       = x_q;
  assign bus.pix_y       = y_q;
  assign bus.frame_start = fs_q;

endmodule

// File: tb/tb_hdmi_period_scheduler.sv
// Runs an HDMI-mode and a DVI-mode scheduler side by side on the small raster
// and compares every output, every cycle, against a raster-position model.
module tb_hdmi_period_scheduler;

  localparam int HA = 8, HF = 2, HS = 3, HB = 12;
  localparam int VA = 4, VF = 1, VS = 2, VB = 1;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;

  typedef struct packed {
    logic        de;
    logic        guard;
    logic [1:0]  ch0;
    logic [1:0]  ch1;
    logic [1:0]  ch2;
    logic        req;
    logic [11:0] x;
    logic [11:0] y;
    logic        fs;
  } out_t;

  logic clk, resetn, en;
  int   n_checks, n_errors;
  bit   mrun;
  int   mh, mv;

  hdmi_period_scheduler_if bus_h ();
  hdmi_period_scheduler_if bus_d ();
  assign bus_h.en = en;
  assign bus_d.en = en;

  hdmi_period_scheduler #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .HSYNC_POL(1'b0), .VSYNC_POL(1'b0), .HDMI_MODE(1'b1)
  ) u_dut_hdmi (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus_h)
  );

  hdmi_period_scheduler #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .HSYNC_POL(1'b0), .VSYNC_POL(1'b0), .HDMI_MODE(1'b0)
  ) u_dut_dvi (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus_d)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s at (h=%0d,v=%0d,run=%0d) got %0h expected %0h",
               tag, mh, mv, mrun, got, exp);
    end
  endtask

  // Expected outputs for the current raster position, straight from the timing rules.
  function automatic out_t model_out(input bit hdmi);
    out_t o;
    bit   hs, vs, nxt_on;
    int   sh, sv;
    o     = '0;
    o.ch0 = 2'b11;
    if (!mrun) return o;
    hs     = (mh >= HA + HF) && (mh < HA + HF + HS);
    vs     = (mv >= VA + VF) && (mv < VA + VF + VS);
    o.ch0  = {~vs, ~hs};
    o.de   = (mv < VA) && (mh < HA);
    nxt_on = ((mv + 1) % VT) < VA;
    if (hdmi && nxt_on && mh >= HT - 10 && mh < HT - 2) o.ch1 = 2'b01;
    if (hdmi && nxt_on && mh >= HT - 2) o.guard = 1'b1;
    sh = (mh + 1) % HT;
    sv = (mh == HT - 1) ? (mv + 1) % VT : mv;
    if (sv < VA && sh < HA) begin
      o.req = 1'b1;
      o.x   = 12'(sh);
      o.y   = 12'(sv);
      o.fs  = (sh == 0) && (sv == 0);
    end
    return o;
  endfunction

  task automatic compare(input string pfx, input out_t g, input out_t e);
    check_val({pfx, ".de"},          32'(g.de),    32'(e.de));
    check_val({pfx, ".guard"},       32'(g.guard), 32'(e.guard));
    check_val({pfx, ".ch0_c"},       32'(g.ch0),   32'(e.ch0));
    check_val({pfx, ".ch1_c"},       32'(g.ch1),   32'(e.ch1));
    check_val({pfx, ".ch2_c"},       32'(g.ch2),   32'(e.ch2));
    check_val({pfx, ".pix_req"},     32'(g.req),   32'(e.req));
    check_val({pfx, ".pix_x"},       32'(g.x),     32'(e.x));
    check_val({pfx, ".pix_y"},       32'(g.y),     32'(e.y));
    check_val({pfx, ".frame_start"}, 32'(g.fs),    32'(e.fs));
  endtask

  task automatic check_both();
    out_t g;
    g = '{de: bus_h.de, guard: bus_h.guard, ch0: bus_h.ch0_c, ch1: bus_h.ch1_c,
          ch2: bus_h.ch2_c, req: bus_h.pix_req, x: bus_h.pix_x, y: bus_h.pix_y,
          fs: bus_h.frame_start};
    compare("hdmi", g, model_out(1'b1));
    g = '{de: bus_d.de, guard: bus_d.guard, ch0: bus_d.ch0_c, ch1: bus_d.ch1_c,
          ch2: bus_d.ch2_c, req: bus_d.pix_req, x: bus_d.pix_x, y: bus_d.pix_y,
          fs: bus_d.frame_start};
    compare("dvi", g, model_out(1'b0));
  endtask

  task automatic model_idle();
    mrun = 1'b0;
    mh   = 0;
    mv   = VA;
  endtask

  // One clock: advance the model at the edge, check all outputs at the falling edge.
  task automatic step();
    @(posedge clk);
    if (!resetn || !en) begin
      model_idle();
    end else if (!mrun) begin
      mrun = 1'b1;
      mh   = 0;
      mv   = VA;
    end else if (mh == HT - 1) begin
      mh = 0;
      mv = (mv + 1) % VT;
    end else begin
      mh++;
    end
    @(negedge clk);
    check_both();
  endtask

  task automatic wait_pos(input int th, input int tv);
    bit hit;
    hit = 1'b0;
    for (int i = 0; i < 2 * HT * VT && !hit; i++) begin
      step();
      hit = mrun && mh == th && mv == tv;
    end
    check_val("wait_pos_reached", 32'(hit), 32'd1);
  endtask

  // Pulse reset between edges and confirm outputs drop before the next edge.
  task automatic reset_pulse(input int hold);
    #2 resetn = 1'b0;
    model_idle();
    #1 check_both();
    repeat (hold) step();
    resetn = 1'b1;
  endtask

  initial begin
    int de_cnt, fs_cnt, hs_cnt, vs_cnt, gd_cnt, gd_dvi, prev_req;
    n_checks = 0;
    n_errors = 0;
    model_idle();
    resetn = 1'b0;
    en     = 1'b1;
    #7 check_both();
    repeat (3) step();
    resetn = 1'b1;

    // Two full frames from reset release.
    de_cnt = 0; fs_cnt = 0; hs_cnt = 0; vs_cnt = 0; gd_cnt = 0; gd_dvi = 0; prev_req = 0;
    for (int i = 0; i < 2 * HT * VT; i++) begin
      step();
      check_val("req_leads_de", 32'(prev_req), 32'(bus_h.de));
      prev_req = int'(bus_h.pix_req);
      de_cnt += int'(bus_h.de);
      fs_cnt += int'(bus_h.frame_start);
      hs_cnt += int'(!bus_h.ch0_c[0]);
      vs_cnt += int'(!bus_h.ch0_c[1]);
      gd_cnt += int'(bus_h.guard);
      gd_dvi += int'(bus_d.guard);
    end
    check_val("de_cycles_2frames",   32'(de_cnt), 32'(2 * VA * HA));
    check_val("frame_start_count",   32'(fs_cnt), 32'd2);
    check_val("hsync_low_cycles",    32'(hs_cnt), 32'(2 * VT * HS));
    check_val("vsync_low_cycles",    32'(vs_cnt), 32'(2 * VS * HT));
    check_val("guard_cycles_hdmi",   32'(gd_cnt), 32'(2 * VA * 2));
    check_val("guard_cycles_dvi",    32'(gd_dvi), 32'd0);

    // Drop en mid-line, hold off, then restart and expect one frame_start per frame.
    wait_pos(4, 2);
    en = 1'b0;
    repeat (5) step();
    en = 1'b1;
    fs_cnt = 0;
    for (int i = 0; i < HT * VT; i++) begin
      step();
      fs_cnt += int'(bus_h.frame_start);
    end
    check_val("frame_start_after_reenable", 32'(fs_cnt), 32'd1);

    // Asynchronous reset mid-video and mid-preamble.
    wait_pos(2, 1);
    reset_pulse(3);
    repeat (HT * VT + 10) step();
    wait_pos(18, VT - 1);
    reset_pulse(2);
    repeat (HT * VT) step();

    // Random en toggles and occasional reset pulses.
    for (int i = 0; i < 1200; i++) begin
      if ($urandom_range(0, 29) == 0) en = ~en;
      if ($urandom_range(0, 249) == 0) reset_pulse(int'($urandom_range(1, 4)));
      else step();
    end
    en = 1'b1;
    repeat (HT * VT) step();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
